pipe_alu_fwd: RTL and testbench

Parametrised single-clock successor to the two-phase four-stage register/ALU/memory pipeline. Each cycle it accepts one instruction (rs1, rs2, rd, func, addr) and reads operands from a register bank. It computes an ALU result, writes it back to `regbank[rd]`, and stores it to `mem[addr]`. New capabilities: a valid qualifier, full operand forwarding so back-to-back dependent instructions need no stalls, extra shift and compare ops, deterministic reset, and a registered memory read-back port. It sits where the two-phase pipe did, as the datapath core driven by the instruction sequencer.

---
 rtl/pipe_alu_fwd_if.sv | 28 ++
 rtl/pipe_alu_fwd.sv | 125 ++++++++++++
 tb/tb_pipe_alu_fwd.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_alu_fwd_if.sv
// Instruction, result and memory read-back signals of the forwarding ALU pipeline.
// in_valid is a pure qualifier with no ready: the pipeline never stalls, so every cycle with in_valid=1 is consumed.
interface pipe_alu_fwd_if #(
    parameter int WIDTH = 16,
    parameter int RAW   = 4,
    parameter int MAW   = 8
);
    logic             in_valid;
    logic [RAW-1:0]   rs1;
    logic [RAW-1:0]   rs2;
    logic [RAW-1:0]   rd;
    logic [3:0]       func;
    logic [MAW-1:0]   addr;
    logic [WIDTH-1:0] z;
    logic             z_valid;
    logic [MAW-1:0]   mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    modport master (
        output in_valid, rs1, rs2, rd, func, addr, mem_raddr,
        input  z, z_valid, mem_rdata
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, func, addr, mem_raddr,
        output z, z_valid, mem_rdata
    );
endinterface

// File: rtl/pipe_alu_fwd.sv
// Three-register ALU pipeline: operand fetch with full forwarding, ALU, register
// write-back and memory store, plus a registered memory read-back port.
module pipe_alu_fwd #(
    parameter int WIDTH = 16,
    parameter int RAW   = 4,
    parameter int MAW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    pipe_alu_fwd_if.slave  bus
);
    localparam int SW   = $clog2(WIDTH);
    localparam int NREG = 2 ** RAW;
    localparam int NMEM = 2 ** MAW;

    // Cleared by reset; the first edge after reset only arms the input.
    logic             armed;

    logic             p1_v;
    logic [WIDTH-1:0] p1_a;
    logic [WIDTH-1:0] p1_b;
    logic [RAW-1:0]   p1_rd;
    logic [3:0]       p1_func;
    logic [MAW-1:0]   p1_addr;

    logic             p2_v;
    logic [WIDTH-1:0] p2_z;
    logic [RAW-1:0]   p2_rd;
    logic [MAW-1:0]   p2_addr;

    logic             p3_v;
    logic [WIDTH-1:0] p3_z;
    logic [MAW-1:0]   p3_addr;

    logic [WIDTH-1:0] regbank [NREG];
    logic [WIDTH-1:0] mem     [NMEM];
    logic [WIDTH-1:0] mem_rdata_q;

    logic [WIDTH-1:0] alu_z;
    logic [WIDTH-1:0] fwd_a;
    logic [WIDTH-1:0] fwd_b;

    always_comb begin
        alu_z = '0;
        case (p1_func)
            4'd0:    alu_z = p1_a + p1_b;
            4'd1:    alu_z = p1_a - p1_b;
            4'd2:    alu_z = p1_a * p1_b;
            4'd3:    alu_z = p1_a;
            4'd4:    alu_z = p1_b;
            4'd5:    alu_z = p1_a & p1_b;
            4'd6:    alu_z = p1_a | p1_b;
            4'd7:    alu_z = p1_a ^ p1_b;
            4'd8:    alu_z = ~p1_a;
            4'd9:    alu_z = ~p1_b;
            4'd10:   alu_z = p1_a >> 1;
            4'd11:   alu_z = p1_a << 1;
            4'd12:   alu_z = p1_a >> p1_b[SW-1:0];
            4'd13:   alu_z = p1_a << p1_b[SW-1:0];
            4'd14:   alu_z = {{(WIDTH-1){1'b0}}, (p1_a < p1_b)};
            default: alu_z = '0;
        endcase
    end

    // Youngest writer wins: the instruction now in the ALU, then the one in P2, then the bank.
    always_comb begin
        fwd_a = regbank[bus.rs1];
        if (p1_v && p1_rd == bus.rs1)      fwd_a = alu_z;
        else if (p2_v && p2_rd == bus.rs1) fwd_a = p2_z;

        fwd_b = regbank[bus.rs2];
        if (p1_v && p1_rd == bus.rs2)      fwd_b = alu_z;
        else if (p2_v && p2_rd == bus.rs2) fwd_b = p2_z;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            p1_v    <= 1'b0;
            p1_a    <= '0;
            p1_b    <= '0;
            p1_rd   <= '0;
            p1_func <= '0;
            p1_addr <= '0;
            p2_v    <= 1'b0;
            p2_z    <= '0;
            p2_rd   <= '0;
            p2_addr <= '0;
            p3_v    <= 1'b0;
            p3_z    <= '0;
            p3_addr <= '0;
            for (int k = 0; k < NREG; k++) regbank[k] <= WIDTH'(k);
        end else begin
            armed   <= 1'b1;
            p1_v    <= bus.in_valid & armed;
            p1_a    <= fwd_a;
            p1_b    <= fwd_b;
            p1_rd   <= bus.rd;
            p1_func <= bus.func;
            p1_addr <= bus.addr;
            p2_v    <= p1_v;
            p2_z    <= alu_z;
            p2_rd   <= p1_rd;
            p2_addr <= p1_addr;
            p3_v    <= p2_v;
            p3_z    <= p2_z;
            p3_addr <= p2_addr;
            if (p2_v) regbank[p2_rd] <= p2_z;
        end
    end

    // Memory contents survive reset; only the store is suppressed at a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && p3_v) mem[p3_addr] <= p3_z;
    end

    always_ff @(posedge clk) begin
        if (rst) mem_rdata_q <= '0;
        else     mem_rdata_q <= mem[bus.mem_raddr];
    end

    assign bus.z         = p2_z;
    assign bus.z_valid   = p2_v;
    assign bus.mem_rdata = mem_rdata_q;
endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Randomized and directed bench for pipe_alu_fwd against a sequential-ISA reference model.
module tb_pipe_alu_fwd;
    localparam int W   = 16;
    localparam int RAW = 4;
    localparam int MAW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_alu_fwd_if #(.WIDTH(W), .RAW(RAW), .MAW(MAW)) bus ();

    pipe_alu_fwd #(.WIDTH(W), .RAW(RAW), .MAW(MAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [MAW-1:0] a;
        logic [W-1:0]   d;
        int             left;
    } st_t;

    // Reference model: architectural registers updated in program order, stores delayed 3 edges.
    logic [W-1:0] m_reg [2**RAW];
    logic [W-1:0] m_mem [2**MAW];
    bit           m_wr  [2**MAW];
    bit           m_armed = 0;
    bit           prev_v = 0;
    logic [W-1:0] exp_q [$];
    st_t          st_q  [$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [W-1:0] ref_alu(input int f, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned ua = a;
        int unsigned ub = b;
        int unsigned sh = ub % W;
        int unsigned r;
        case (f)
            0:  r = ua + ub;
            1:  r = ua - ub;
            2:  r = ua * ub;
            3:  r = ua;
            4:  r = ub;
            5:  r = ua & ub;
            6:  r = ua | ub;
            7:  r = ua ^ ub;
            8:  r = 32'hFFFF - ua;
            9:  r = 32'hFFFF - ub;
            10: r = ua / 2;
            11: r = ua * 2;
            12: r = ua / (32'd1 << sh);
            13: r = ua * (32'd1 << sh);
            14: r = (ua < ub) ? 1 : 0;
            default: r = 0;
        endcase
        return W'(r % (32'd1 << W));
    endfunction

    task automatic cycle(input bit r, input bit v, input int s1, input int s2, input int d,
                         input int f, input int a);
        logic [W-1:0] res;
        logic [W-1:0] exp_z;
        logic [W-1:0] exp_rd;
        bit           acc, exp_zv, rd_ok;
        st_t          e;
        st_t          nq [$];
        rst          = r;
        bus.in_valid = v;
        bus.rs1      = RAW'(s1);
        bus.rs2      = RAW'(s2);
        bus.rd       = RAW'(d);
        bus.func     = 4'(f);
        bus.addr     = MAW'(a);
        @(posedge clk);
        acc    = v && !r && m_armed;
        rd_ok  = !r && m_wr[bus.mem_raddr];
        exp_rd = m_mem[bus.mem_raddr];
        res    = '0;
        exp_z  = '0;
        if (acc) res = ref_alu(f, m_reg[s1], m_reg[s2]);
        exp_zv = !r && prev_v;
        if (r) begin
            exp_q.delete();
            st_q.delete();
            for (int k = 0; k < 2**RAW; k++) m_reg[k] = W'(k);
        end else begin
            if (prev_v) exp_z = exp_q.pop_front();
            foreach (st_q[i]) begin
                e = st_q[i];
                e.left--;
                if (e.left == 0) begin
                    m_mem[e.a] = e.d;
                    m_wr[e.a]  = 1;
                end else nq.push_back(e);
            end
            st_q = nq;
        end
        if (acc) begin
            m_reg[d] = res;
            exp_q.push_back(res);
            st_q.push_back('{MAW'(a), res, 3});
        end
        prev_v  = acc;
        m_armed = !r;
        #1;
        check("z_valid", W'(bus.z_valid), W'(exp_zv));
        if (exp_zv) check("z", bus.z, exp_z);
        if (r) begin
            check("z_rst", bus.z, '0);
            check("mem_rdata_rst", bus.mem_rdata, '0);
        end
        if (rd_ok) check("mem_rdata", bus.mem_rdata, exp_rd);
    endtask

    task automatic bubble();
        cycle(0, 0, 0, 0, 0, 15, 0);
    endtask

    // Two reset edges, then one edge whose instruction must be ignored.
    task automatic do_reset();
        cycle(1, 1, 1, 2, 3, 0, 200);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 2, 9, 0, 201);
    endtask

    task automatic readback(input int a);
        bus.mem_raddr = MAW'(a);
        bubble();
    endtask

    task automatic read_reg(input int k);
        cycle(0, 1, k, 0, 15, 3, 250);
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.rd        = '0;
        bus.func      = '0;
        bus.addr      = '0;
        bus.mem_raddr = '0;
        foreach (m_wr[i]) m_wr[i] = 0;
        foreach (m_reg[i]) m_reg[i] = '0;

        // Single op
        do_reset();
        cycle(0, 1, 3, 5, 10, 0, 125);
        repeat (4) bubble();
        readback(125);
        read_reg(10);
        bubble();

        // Forward distance 1
        do_reset();
        cycle(0, 1, 3, 5, 10, 0, 125);
        cycle(0, 1, 10, 5, 14, 1, 126);
        repeat (4) bubble();
        readback(126);
        read_reg(14);
        bubble();

        // Forward distance 2 and youngest-writer priority
        do_reset();
        cycle(0, 1, 3, 8, 12, 2, 127);
        cycle(0, 1, 12, 1, 12, 0, 128);
        cycle(0, 1, 12, 5, 13, 1, 129);
        repeat (4) bubble();
        readback(127);
        readback(128);
        readback(129);

        // Wrap and new ops
        do_reset();
        cycle(0, 1, 0, 0, 1, 8, 130);
        cycle(0, 1, 1, 1, 2, 0, 131);
        cycle(0, 1, 0, 1, 3, 14, 132);
        cycle(0, 1, 7, 3, 4, 13, 133);
        cycle(0, 1, 9, 9, 5, 15, 134);
        repeat (4) bubble();
        for (int a = 130; a <= 134; a++) readback(a);

        // Bubbles interleaved with the dependent pair
        do_reset();
        cycle(0, 1, 3, 5, 10, 0, 135);
        bubble();
        cycle(0, 1, 10, 5, 14, 1, 136);
        bubble();
        repeat (3) bubble();
        readback(135);
        readback(136);
        read_reg(14);
        bubble();

        // Reset mid-operation: stores to previously written addresses must not happen
        do_reset();
        cycle(0, 1, 1, 2, 6, 0, 125);
        cycle(0, 1, 3, 4, 7, 0, 126);
        cycle(0, 1, 5, 6, 8, 0, 127);
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 2, 2, 9, 0, 128);
        repeat (3) bubble();
        readback(125);
        readback(126);
        readback(127);
        for (int k = 0; k < 2**RAW; k++) read_reg(k);
        cycle(0, 1, 3, 5, 10, 0, 140);
        repeat (4) bubble();
        readback(140);

        // Random traffic on a small register/address window to provoke hazards
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.mem_raddr = MAW'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15));
        end
        repeat (4) bubble();
        for (int a = 0; a < 16; a++) readback(a);
        for (int k = 0; k < 4; k++) read_reg(k);
        bubble();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
